// File: rtl/polaris_bus_pkg.sv
// Shared definitions for the Polaris 16-bit external bus.
// Contents:
//   SZ_*      transfer size encodings (00 idle, 01 byte, 10 halfword, 11 illegal)
//   own_e     arbiter ownership state
//   bus_req_t one master's outbound bundle (address, size, write enable, vpa, data)
//   is_req    returns 1 when a size field is a real request (byte or halfword)
package polaris_bus_pkg;

  localparam logic [1:0] SZ_IDLE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_e;

  typedef struct packed {
    logic [63:0] adr;
    logic [1:0]  size;
    logic        we;
    logic        vpa;
    logic [15:0] dat;
  } bus_req_t;

  // The illegal encoding is deliberately treated the same as idle.
  function automatic logic is_req(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/bus_arbiter_mux.sv
// Pure 2:1 routing of the outbound bus bundle.
// Ports:
//   sel_i_i  route the fetch bundle
//   sel_d_i  route the data bundle (never asserted together with sel_i_i)
//   i_bus_i  fetch bundle
//   d_bus_i  data bundle
//   bus_o    external bundle; all zero when nothing is selected
module bus_arbiter_mux
  import polaris_bus_pkg::*;
(
  input  logic     sel_i_i,
  input  logic     sel_d_i,
  input  bus_req_t i_bus_i,
  input  bus_req_t d_bus_i,
  output bus_req_t bus_o
);

  always_comb begin
    bus_o = '0;
    if (sel_i_i) begin
      bus_o = i_bus_i;
    end else if (sel_d_i) begin
      bus_o = d_bus_i;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (fetch I-port, load/store D-port), one-slave arbiter for the
// Polaris external bus. A grant is held from the first cycle until ack; in
// IDLE the winner is passed through in the same cycle.
// Ports:
//   clk_i, reset_i             clock, asynchronous active-low reset
//   i_adr_i/i_size_i/i_vpa_i   fetch request; i_dat_o/i_ack_o fetch response
//   d_adr_i/d_size_i/d_we_i/d_dat_i  data request; d_dat_o/d_ack_o data response
//   adr_o/size_o/we_o/vpa_o/dat_o    external request
//   dat_i/ack_i                external response
module bus_arbiter
  import polaris_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] i_adr_i,
  input  logic [1:0]  i_size_i,
  input  logic        i_vpa_i,
  output logic [15:0] i_dat_o,
  output logic        i_ack_o,
  input  logic [63:0] d_adr_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_we_i,
  input  logic [15:0] d_dat_i,
  output logic [15:0] d_dat_o,
  output logic        d_ack_o,
  output logic [63:0] adr_o,
  output logic [1:0]  size_o,
  output logic        we_o,
  output logic        vpa_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  own_e       own_q, own_d;
  logic [1:0] scnt_q, scnt_d;

  logic     i_req, d_req, i_win, d_win;
  logic     route_i, route_d;   // whose bundle drives the external bus
  logic     tgt_i, tgt_d;       // who receives ack_i/dat_i
  bus_req_t i_bus, d_bus, ext_bus;

  // Gating with reset_i drops the bus at once while reset is held, even
  // though the masters keep requesting.
  assign i_req = reset_i && is_req(i_size_i);
  assign d_req = reset_i && is_req(d_size_i);

  // D has priority unless I has already been passed over LIMIT times.
  assign i_win = i_req && (!d_req || (scnt_q == LIMIT));
  assign d_win = d_req && !i_win;

  always_comb begin
    route_i = 1'b0;
    route_d = 1'b0;
    tgt_i   = 1'b0;
    tgt_d   = 1'b0;
    own_d   = own_q;
    scnt_d  = scnt_q;
    case (own_q)
      OWN_IDLE: begin
        route_i = i_win;
        route_d = d_win;
        tgt_i   = i_win;
        tgt_d   = d_win;
        if (i_win && !ack_i) begin
          own_d = OWN_I;
        end else if (d_win && !ack_i) begin
          own_d = OWN_D;
        end
      end
      OWN_I: begin
        // A dropped request aborts the bus but a coincident ack still
        // reaches the owner and counts as completion.
        route_i = i_req;
        tgt_i   = 1'b1;
        if (ack_i || !i_req) begin
          own_d = OWN_IDLE;
        end
      end
      OWN_D: begin
        route_d = d_req;
        tgt_d   = 1'b1;
        if (ack_i || !d_req) begin
          own_d = OWN_IDLE;
        end
      end
      default: begin
        own_d = OWN_IDLE;
      end
    endcase

    if (tgt_d && ack_i) begin
      if (i_req) begin
        scnt_d = (scnt_q == LIMIT) ? LIMIT : scnt_q + 2'd1;
      end else begin
        scnt_d = 2'd0;
      end
    end
    if (tgt_i && ack_i) begin
      scnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      own_q  <= OWN_IDLE;
      scnt_q <= 2'd0;
    end else begin
      own_q  <= own_d;
      scnt_q <= scnt_d;
    end
  end

  // Fetch never writes and carries no store data; data never sets vpa.
  assign i_bus = '{adr: i_adr_i, size: i_size_i, we: 1'b0, vpa: i_vpa_i, dat: 16'h0000};
  assign d_bus = '{adr: d_adr_i, size: d_size_i, we: d_we_i, vpa: 1'b0, dat: d_dat_i};

  bus_arbiter_mux u_mux (
    .sel_i_i (route_i),
    .sel_d_i (route_d),
    .i_bus_i (i_bus),
    .d_bus_i (d_bus),
    .bus_o   (ext_bus)
  );

  assign adr_o  = ext_bus.adr;
  assign size_o = ext_bus.size;
  assign we_o   = ext_bus.we;
  assign vpa_o  = ext_bus.vpa;
  assign dat_o  = ext_bus.dat;

  assign i_ack_o = tgt_i && ack_i;
  assign d_ack_o = tgt_d && ack_i;
  assign i_dat_o = tgt_i ? dat_i : 16'h0000;
  assign d_dat_o = tgt_d ? dat_i : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam logic [63:0] I_ADR = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [63:0] D_ADR = 64'h0000_0000_0000_1000;
  localparam logic [15:0] D_DAT = 16'h1234;
  localparam logic [15:0] X_DAT = 16'hAAAA;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] i_adr_i, d_adr_i, adr_o;
  logic [1:0]  i_size_i, d_size_i, size_o;
  logic        i_vpa_i, d_we_i, we_o, vpa_o, ack_i, i_ack_o, d_ack_o;
  logic [15:0] d_dat_i, i_dat_o, d_dat_o, dat_o, dat_i;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .i_adr_i(i_adr_i), .i_size_i(i_size_i), .i_vpa_i(i_vpa_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
    .d_adr_i(d_adr_i), .d_size_i(d_size_i), .d_we_i(d_we_i), .d_dat_i(d_dat_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
    .adr_o(adr_o), .size_o(size_o), .we_o(we_o), .vpa_o(vpa_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  // esel: whose bundle is on the bus (0 none, 1 I, 2 D)
  // etgt: who receives ack_i/dat_i   (0 none, 1 I, 2 D)
  typedef struct {
    logic       rst;
    logic [1:0] isz;
    logic [1:0] dsz;
    logic       dwe;
    logic       ack;
    int         esel;
    int         etgt;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s actual=%h required=%h", idx, nm, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [1:0] isz, input logic [1:0] dsz,
                               input logic dwe, input logic ack, input int esel, input int etgt);
    logic [63:0] e_adr;
    logic [1:0]  e_size;
    logic [15:0] e_dat;
    e_adr  = (esel == 1) ? I_ADR : (esel == 2) ? D_ADR : 64'h0;
    e_size = (esel == 1) ? isz : (esel == 2) ? dsz : 2'b00;
    e_dat  = (esel == 2) ? D_DAT : 16'h0;
    chk("adr_o",   idx, adr_o,   e_adr);
    chk("size_o",  idx, 64'(size_o), 64'(e_size));
    chk("we_o",    idx, 64'(we_o),   64'((esel == 2) && dwe));
    chk("vpa_o",   idx, 64'(vpa_o),  64'(esel == 1));
    chk("dat_o",   idx, 64'(dat_o),  64'(e_dat));
    chk("i_ack_o", idx, 64'(i_ack_o), 64'((etgt == 1) && ack));
    chk("d_ack_o", idx, 64'(d_ack_o), 64'((etgt == 2) && ack));
    chk("i_dat_o", idx, 64'(i_dat_o), 64'((etgt == 1) ? X_DAT : 16'h0));
    chk("d_dat_o", idx, 64'(d_dat_o), 64'((etgt == 2) ? X_DAT : 16'h0));
    $display("vec %0d rst=%b isz=%b dsz=%b we=%b ack=%b -> adr=%h size=%b iack=%b dack=%b",
             idx, reset_i, isz, dsz, dwe, ack, adr_o, size_o, i_ack_o, d_ack_o);
  endtask

  task automatic drive(input logic rst, input logic [1:0] isz, input logic [1:0] dsz,
                       input logic dwe, input logic ack);
    reset_i  = rst;
    i_size_i = isz;
    d_size_i = dsz;
    d_we_i   = dwe;
    ack_i    = ack;
  endtask

  initial begin
    //           rst   isz    dsz    we    ack  esel etgt
    vecs[0]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 0, 0}; // held in reset, both requesting
    vecs[1]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 2, 2}; // release: D wins, scnt=1
    vecs[2]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 2, 2}; // D, scnt=2
    vecs[3]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1, 1}; // I forced, scnt=0
    vecs[4]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 2, 2}; // D
    vecs[5]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 2, 2}; // D
    vecs[6]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1, 1}; // I
    vecs[7]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1, 1}; // lone fetch
    vecs[8]  = '{1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 2, 2}; // store
    vecs[9]  = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 0, 0}; // illegal size = no request
    vecs[10] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1, 1}; // fetch granted, no ack
    vecs[11] = '{1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1, 1}; // hold despite D
    vecs[12] = '{1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1, 1}; // hold
    vecs[13] = '{1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 1, 1}; // ack ends fetch
    vecs[14] = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 2, 2}; // D granted next
    vecs[15] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 2, 2}; // D holds, fetch waits
    vecs[16] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 0, 2}; // D aborts: size_o=00
    vecs[17] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1, 1}; // pending fetch granted
    vecs[18] = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 2, 2}; // D owns
    vecs[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 0, 2}; // drop + ack: ack forwarded
    vecs[20] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0}; // idle
    vecs[21] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1, 1}; // I owns
    vecs[22] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 0, 0}; // reset mid-transfer
    vecs[23] = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 2, 2}; // state was cleared

    i_adr_i = I_ADR;
    i_vpa_i = 1'b1;
    d_adr_i = D_ADR;
    d_dat_i = D_DAT;
    dat_i   = X_DAT;
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].isz, vecs[i].dsz, vecs[i].dwe, vecs[i].ack);
      @(negedge clk_i);
      check_outputs(i, vecs[i].isz, vecs[i].dsz, vecs[i].dwe, vecs[i].ack,
                    vecs[i].esel, vecs[i].etgt);
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset in the middle of a D transfer, between clock edges.
    drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    @(posedge clk_i);
    #2;
    check_outputs(100, 2'b00, 2'b10, 1'b0, 1'b0, 2, 2);
    ack_i   = 1'b1;
    reset_i = 1'b0;
    #1;
    check_outputs(101, 2'b00, 2'b10, 1'b0, 1'b1, 0, 0);
    @(posedge clk_i);
    #1;
    drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b1);
    @(negedge clk_i);
    check_outputs(102, 2'b10, 2'b00, 1'b0, 1'b1, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
